spi_master: RTL and testbench

Mode-0 SPI initiator (CPOL=0, CPHA=0, 8-bit frames, MSB first, active-low chip select) that drives the SCK/MOSI/SS lines toward the design's SPI slave-side logic and captures MISO. A host issues a byte with a start/busy handshake. The block generates the chip-select envelope and a divided SCK, and returns the received byte with a one-cycle done pulse. It sits in the same clock domain as the slave-side logic. Setup, hold and idle margins are sized for a slave that double-synchronizes SS/SCK/MOSI and edge-detects SCK.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync2.sv | 19 +
 rtl/spi_master.sv | 121 ++++++++++++
 tb/tb_spi_master.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding, default timing constants and helpers for spi_master
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;
    localparam int SPI_HALF_PERIOD_DEF = 8;
    localparam int SPI_CS_SETUP_DEF    = 8;
    localparam int SPI_CS_HOLD_DEF     = 8;
    localparam int SPI_CS_IDLE_DEF     = 8;
    localparam int SPI_MIN_MARGIN      = 4;
    function automatic int spi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return (d > m) ? d : m;
    endfunction
endpackage

// File: rtl/spi_sync2.sv
// spi_sync2: two-flop synchronizer, sync active-high reset to 0
// ports: clk, rst, d (async in), q (synchronized out)
module spi_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator, 8-bit MSB-first frames with start/busy/done host handshake
// ports: clk, rst (sync, active high); start, tx_data -> busy, done, rx_data; SCK, MOSI, SS out; MISO in
// SPI_MASTER_LOOPBACK_EN: when defined, MOSI feeds the MISO synchronizer and the MISO port is ignored
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = SPI_HALF_PERIOD_DEF,
    parameter int CS_SETUP    = SPI_CS_SETUP_DEF,
    parameter int CS_HOLD     = SPI_CS_HOLD_DEF,
    parameter int CS_IDLE     = SPI_CS_IDLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SCK,
    output logic       MOSI,
    output logic       SS,
    input  logic       MISO
);
    localparam int MAXP = spi_max4(HALF_PERIOD, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int CW   = $clog2(MAXP);

    if (HALF_PERIOD < SPI_MIN_MARGIN || CS_SETUP < SPI_MIN_MARGIN ||
        CS_HOLD < SPI_MIN_MARGIN || CS_IDLE < SPI_MIN_MARGIN) begin : g_bad_param
        $error("spi_master: timing parameter below minimum margin");
    end

    state_t        state, nstate;
    logic [CW-1:0] cnt, rld;
    logic [7:0]    tx_sh, rx_sh;
    logic [3:0]    bits;
    logic          miso_src, miso_sync, tc;
    logic          accept, setup_end, hi_end, lo_end, hold_end, gap_end;
    logic          ss_n, sck_n, mosi_n, busy_n;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_src = MOSI;
`else
    assign miso_src = MISO;
`endif

    spi_sync2 u_miso_sync (
        .clk(clk),
        .rst(rst),
        .d  (miso_src),
        .q  (miso_sync)
    );

    assign tc = (cnt == '0);

    // every state entry reloads the shared counter with its duration minus one
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= (nstate != state) ? rld : (tc ? cnt : cnt - 1'b1);
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    nstate = start ? SETUP : IDLE;
            SETUP:   nstate = tc ? SCK_HI : SETUP;
            SCK_HI:  nstate = tc ? ((bits == 4'd7) ? HOLD : SCK_LO) : SCK_HI;
            SCK_LO:  nstate = tc ? SCK_HI : SCK_LO;
            HOLD:    nstate = tc ? GAP : HOLD;
            GAP:     nstate = tc ? IDLE : GAP;
            default: nstate = IDLE;
        endcase
        rld = (nstate == SETUP) ? CW'(CS_SETUP - 1) :
              (nstate == HOLD)  ? CW'(CS_HOLD - 1)  :
              (nstate == GAP)   ? CW'(CS_IDLE - 1)  : CW'(HALF_PERIOD - 1);
    end

    always_comb begin
        accept    = (state == IDLE) && start;
        setup_end = (state == SETUP) && tc;
        hi_end    = (state == SCK_HI) && tc;
        lo_end    = (state == SCK_LO) && tc;
        hold_end  = (state == HOLD) && tc;
        gap_end   = (state == GAP) && tc;
        ss_n      = accept ? 1'b0 : (hold_end ? 1'b1 : SS);
        sck_n     = (setup_end || lo_end) ? 1'b1 : (hi_end ? 1'b0 : SCK);
        // tx_sh[6] is the next bit to present since tx_sh shifts on the same edge
        mosi_n    = accept ? tx_data[7] :
                    (hi_end && bits != 4'd7) ? tx_sh[6] :
                    hold_end ? 1'b0 : MOSI;
        busy_n    = accept ? 1'b1 : (gap_end ? 1'b0 : busy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SS      <= 1'b1;
            SCK     <= 1'b0;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= 8'h00;
            tx_sh   <= 8'h00;
            rx_sh   <= 8'h00;
            bits    <= 4'd0;
        end else begin
            SS      <= ss_n;
            SCK     <= sck_n;
            MOSI    <= mosi_n;
            busy    <= busy_n;
            done    <= hold_end;
            rx_data <= hold_end ? rx_sh : rx_data;
            tx_sh   <= accept ? tx_data : (hi_end ? {tx_sh[6:0], 1'b0} : tx_sh);
            rx_sh   <= hi_end ? {rx_sh[6:0], miso_sync} : rx_sh;
            bits    <= accept ? 4'd0 : (hi_end ? bits + 4'd1 : bits);
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed self-checking bench for spi_master against a mode-0 slave model
module tb_spi_master;
    localparam int H = 8, S = 8, HD = 8, I = 8;
    localparam int EXP_RISE = 1 + S;
    localparam int EXP_DONE = 1 + S + 15 * H + HD;
    localparam int EXP_BUSY = EXP_DONE + I;
    localparam int EXP_DONE4 = 1 + 4 + 15 * 4 + 4;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, MISO = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic busy, done, SCK, MOSI, SS;
    logic [7:0] rx_data;

    logic start4 = 1'b0, miso4 = 1'b0;
    logic [7:0] tx4 = 8'h00;
    logic busy4, done4, sck4, mosi4, ss4;
    logic [7:0] rx4;

    int nvec = 0, nerr = 0, dcount = 0;
    logic [7:0] prev_rx = 8'h00;
    logic [7:0] slv_q[$];
    logic [7:0] sl = 8'h00, sl4 = 8'h00;

    always #5 clk = ~clk;

    spi_master dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
        .rx_data(rx_data), .SCK(SCK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
    );

    spi_master #(.HALF_PERIOD(4), .CS_SETUP(4), .CS_HOLD(4), .CS_IDLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .tx_data(tx4), .busy(busy4), .done(done4),
        .rx_data(rx4), .SCK(sck4), .MOSI(mosi4), .SS(ss4), .MISO(miso4)
    );

    // mode-0 slave: presents MSB when selected, next bit after every falling SCK
    always @(negedge SS) begin
        sl = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
        MISO = sl[7];
    end
    always @(negedge SCK) if (!SS) begin
        sl = {sl[6:0], 1'b0};
        MISO = sl[7];
    end
    always @(negedge ss4) begin
        sl4 = 8'h81;
        miso4 = sl4[7];
    end
    always @(negedge sck4) if (!ss4) begin
        sl4 = {sl4[6:0], 1'b0};
        miso4 = sl4[7];
    end
    always @(posedge clk) if (done === 1'b1) dcount++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sv);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return sv;
`endif
    endfunction

    task automatic go(input logic [7:0] tx);
        @(negedge clk);
        tx_data = tx;
        start = 1'b1;
        @(posedge clk);
    endtask

    // follows one frame from the cycle after its accept edge until busy drops
    task automatic mon(input logic [7:0] etx, input logic [7:0] erx, input bit keep,
                       input logic [7:0] nxt, input bit poke);
        int c = 0, rise_c = 0, done_c = 0, done_n = 0, rises = 0;
        logic [7:0] mb = 8'h00;
        logic psck = 1'b0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check("ss_fall", SS, 0);
                check("busy_up", busy, 1);
                check("rx_held", rx_data, prev_rx);
                if (keep) tx_data = nxt;
                else begin
                    start = 1'b0;
                    tx_data = 8'($urandom);
                end
            end
            if (poke && c == 50) begin
                start = 1'b1;
                tx_data = 8'($urandom);
            end
            if (poke && c == 51) start = 1'b0;
            if (SCK && !psck) begin
                rises++;
                mb = {mb[6:0], MOSI};
                if (rise_c == 0) rise_c = c;
            end
            psck = SCK;
            if (done) begin
                done_n++;
                if (done_c == 0) begin
                    done_c = c;
                    check("ss_rise_with_done", SS, 1);
                    check("rx_data", rx_data, erx);
                end
            end
        end while (busy && c < 1000);
        check("first_rise_cycle", rise_c, EXP_RISE);
        check("done_cycle", done_c, EXP_DONE);
        check("busy_low_cycle", c, EXP_BUSY);
        check("sck_rises", rises, 8);
        check("mosi_bits", mb, etx);
        check("done_pulses", done_n, 1);
        prev_rx = erx;
    endtask

    initial begin
        logic [7:0] t, s, t2, s2;
        int c, lows;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ss", SS, 1);
        check("rst_sck", SCK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 8'h00);
        check("rst_ss4", ss4, 1);

        slv_q.push_back(8'h3C);
        go(8'hA5);
        mon(8'hA5, exp_rx(8'hA5, 8'h3C), 1'b0, 8'h00, 1'b0);

        t = 8'($urandom);
        s = 8'($urandom);
        slv_q.push_back(s);
        go(t);
        mon(t, exp_rx(t, s), 1'b0, 8'h00, 1'b1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!SS) lows++;
        end
        check("ignored_start_no_frame", lows, 0);

        slv_q.push_back(8'h5E);
        slv_q.push_back(8'hC3);
        go(8'h01);
        mon(8'h01, exp_rx(8'h01, 8'h5E), 1'b1, 8'hFF, 1'b0);
        mon(8'hFF, exp_rx(8'hFF, 8'hC3), 1'b0, 8'h00, 1'b0);

        repeat (5) begin
            t2 = 8'($urandom);
            s2 = 8'($urandom);
            slv_q.push_back(s2);
            go(t2);
            mon(t2, exp_rx(t2, s2), 1'b0, 8'h00, 1'b0);
        end

        slv_q.push_back(8'h99);
        go(8'h77);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!SCK && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("reached_sck_hi", SCK, 1);
        repeat (3) @(negedge clk);
        dcount = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ss", SS, 1);
        check("midrst_sck", SCK, 0);
        check("midrst_mosi", MOSI, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rx", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_no_done", dcount, 0);
        check("midrst_idle_ss", SS, 1);

        @(negedge clk);
        tx4 = 8'($urandom);
        start4 = 1'b1;
        @(posedge clk);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) start4 = 1'b0;
        end while (!done4 && c < 300);
        check("p4_done_cycle", c, EXP_DONE4);
        check("p4_rx", rx4, exp_rx(tx4, 8'h81));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
